// File: rtl/sevenseg_pkg.sv
// Shared types and active-low segment encodings for the 4-digit seven-segment scanner.
package sevenseg_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam int NUM_DIGITS = 4;

    // Active-low cathode patterns, seg[0]=a .. seg[6]=g
    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        DIG_ONES      = 2'd0,
        DIG_TENS      = 2'd1,
        DIG_HUNDREDS  = 2'd2,
        DIG_THOUSANDS = 2'd3
    } dig_e;

    function automatic logic [3:0] anode_onehot_n(input dig_e idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_sevenseg_scan_if.sv
// Digit-load and display bus between a BCD source and the seven-segment scanner.
interface bcd_sevenseg_scan_if;
    import sevenseg_pkg::*;

    logic       valid;
    bcd_t       thousands;
    bcd_t       hundreds;
    bcd_t       tens;
    bcd_t       ones;
    logic [3:0] dp_mask;
    logic [3:0] an;
    seg_t       seg;
    logic       dp_n;
    logic       frame_done;

    modport master (
        output valid, thousands, hundreds, tens, ones, dp_mask,
        input  an, seg, dp_n, frame_done
    );

    modport slave (
        input  valid, thousands, hundreds, tens, ones, dp_mask,
        output an, seg, dp_n, frame_done
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// BCD to active-low seven-segment decoder; non-decimal codes decode to blank.
module bcd_to_7seg
    import sevenseg_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Time-multiplexed 4-digit common-anode driver with frame-synchronous digit update,
// leading-zero blanking and decimal points.
module bcd_sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int TICK_DIV = 100_000,
    parameter bit BLANK_LZ = 1'b1
)
(
    input  logic               clk,
    input  logic               rst_n,
    bcd_sevenseg_scan_if.slave bus
);

    localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    dig_e             idx_reg;
    bcd_t             pend_digit_reg   [NUM_DIGITS];
    logic [3:0]       pend_dp_reg;
    bcd_t             shadow_digit_reg [NUM_DIGITS];
    logic [3:0]       shadow_dp_reg;
    logic             wrap_d_reg;

    logic [3:0]       an_reg;
    seg_t             seg_reg;
    logic             dp_n_reg;
    logic             frame_done_reg;

    bcd_t             in_digit [NUM_DIGITS];
    logic [1:0]       idx_bits;
    logic             tick;
    logic             wrap;

    assign in_digit[0] = bus.ones;
    assign in_digit[1] = bus.tens;
    assign in_digit[2] = bus.hundreds;
    assign in_digit[3] = bus.thousands;

    assign idx_bits = idx_reg;
    assign tick     = (div_reg == DIV_LAST);
    assign wrap     = tick && (idx_reg == DIG_THOUSANDS);

    // A digit is blank when it and every more significant digit are zero
    logic [NUM_DIGITS-1:0] blank_vec;
    assign blank_vec[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign blank_vec[gi] = BLANK_LZ && (shadow_digit_reg[gi] == 4'd0);
            end else begin : g_mid
                assign blank_vec[gi] = blank_vec[gi+1] && (shadow_digit_reg[gi] == 4'd0);
            end
        end
    endgenerate

    bcd_t       digit_sel;
    seg_t       seg_dec;
    seg_t       seg_next;
    logic       dp_n_next;
    logic [3:0] an_next;

    assign digit_sel = shadow_digit_reg[idx_bits];
    assign seg_next  = blank_vec[idx_bits] ? SEG_BLANK : seg_dec;
    assign dp_n_next = ~shadow_dp_reg[idx_bits];
    assign an_next   = anode_onehot_n(idx_reg);

    bcd_to_7seg u_dec (
        .bcd (digit_sel),
        .seg (seg_dec)
    );

    // Scan timing and the pending/shadow double buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg       <= '0;
            idx_reg       <= DIG_ONES;
            pend_dp_reg   <= '0;
            shadow_dp_reg <= '0;
            wrap_d_reg    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pend_digit_reg[i]   <= '0;
                shadow_digit_reg[i] <= '0;
            end
        end else begin
            div_reg    <= tick ? '0 : div_reg + DIV_W'(1);
            wrap_d_reg <= wrap;
            if (tick) begin
                idx_reg <= dig_e'(idx_bits + 2'd1);
            end
            if (bus.valid) begin
                pend_digit_reg <= in_digit;
                pend_dp_reg    <= bus.dp_mask;
            end
            // A load coinciding with the wrap goes straight to the display
            if (wrap) begin
                if (bus.valid) begin
                    shadow_digit_reg <= in_digit;
                    shadow_dp_reg    <= bus.dp_mask;
                end else begin
                    shadow_digit_reg <= pend_digit_reg;
                    shadow_dp_reg    <= pend_dp_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg         <= 4'b1111;
            seg_reg        <= SEG_BLANK;
            dp_n_reg       <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_n_reg       <= dp_n_next;
            frame_done_reg <= wrap_d_reg;
        end
    end

    assign bus.an         = an_reg;
    assign bus.seg        = seg_reg;
    assign bus.dp_n       = dp_n_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
